nibble_sum_sequencer: RTL

Transaction wrapper around the combinational nibble adder, which is instantiated outside this block. It accepts an 8-bit operand pair over a valid/ready handshake and drives the adder's A, B and ctrl inputs. It samples the low-nibble sum, then the high-nibble sum, and recombines them into the full 9-bit sum. Results go out on a valid/ready interface to downstream logic, and a completed-transaction counter is kept for debug.

---
 rtl/nibble_sum_sequencer_pkg.sv | 14 +
 rtl/nibble_sum_sequencer_if.sv | 24 ++
 rtl/nibble_sum_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/nibble_sum_sequencer_pkg.sv
// Shared types and default sizes for the nibble sum sequencer and its bench.
package nibble_sum_sequencer_pkg;

    localparam int unsigned NIB_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/nibble_sum_sequencer_if.sv
// Operand-in / result-out valid-ready bus of the nibble sum sequencer.
interface nibble_sum_sequencer_if #(
    parameter int unsigned NIB_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*NIB_W-1:0]   in_a;
    logic [2*NIB_W-1:0]   in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [NIB_W:0]       out_lo;
    logic [NIB_W:0]       out_hi;
    logic [2*NIB_W:0]     out_sum;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_lo, out_hi, out_sum
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_lo, out_hi, out_sum
    );
endinterface

// File: rtl/nibble_sum_sequencer.sv
// Sequences an external nibble adder over low then high nibbles and
// recombines the two partial sums into the full operand sum.
module nibble_sum_sequencer
    import nibble_sum_sequencer_pkg::*;
#(
    parameter int unsigned NIB_W = NIB_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_sum_sequencer_if.slave    bus,
    output logic [2*NIB_W-1:0]       add_a,
    output logic [2*NIB_W-1:0]       add_b,
    output logic                     add_ctrl,
    input  logic [NIB_W:0]           add_q,
    output logic [CNT_W-1:0]         done_cnt
);

    localparam int unsigned OP_W  = 2 * NIB_W;
    localparam int unsigned NS_W  = NIB_W + 1;
    localparam int unsigned SUM_W = 2 * NIB_W + 1;

    state_e             state_q,     state_d;
    logic [OP_W-1:0]    op_a_q,      op_a_d;
    logic [OP_W-1:0]    op_b_q,      op_b_d;
    logic [NS_W-1:0]    out_lo_q,    out_lo_d;
    logic [NS_W-1:0]    out_hi_q,    out_hi_d;
    logic [SUM_W-1:0]   out_sum_q,   out_sum_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q,  in_ready_d;
    logic               add_ctrl_q,  add_ctrl_d;
    logic [CNT_W-1:0]   done_cnt_q,  done_cnt_d;

    // Next-state and datapath; add_q is only looked at in LO/HI so X elsewhere stays out.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        out_lo_d    = out_lo_q;
        out_hi_d    = out_hi_q;
        out_sum_d   = out_sum_q;
        done_cnt_d  = done_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    op_a_d  = bus.in_a;
                    op_b_d  = bus.in_b;
                    state_d = LO;
                end
            end
            LO: begin
                out_lo_d = add_q;
                state_d  = HI;
            end
            HI: begin
                out_hi_d  = add_q;
                out_sum_d = (SUM_W'(add_q) << NIB_W) + SUM_W'(out_lo_q);
                state_d   = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    done_cnt_d = done_cnt_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are decoded from the next state so they register alongside it.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        add_ctrl_d  = (state_d == HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            out_lo_q    <= '0;
            out_hi_q    <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            add_ctrl_q  <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            out_lo_q    <= out_lo_d;
            out_hi_q    <= out_hi_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            add_ctrl_q  <= add_ctrl_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_lo    = out_lo_q;
    assign bus.out_hi    = out_hi_q;
    assign bus.out_sum   = out_sum_q;
    assign add_a         = op_a_q;
    assign add_b         = op_b_q;
    assign add_ctrl      = add_ctrl_q;
    assign done_cnt      = done_cnt_q;

endmodule
